delay_seq_ctrl: RTL and testbench

- Controller that sequences an external single-clock 16-bit sample FIFO (depth 4096) to form a programmable sample delay line.
- Drives FIFO write/read enables from a sample strobe and tracks FIFO occupancy internally.
- Retunes the delay at run time by growing (write-only) or shrinking (double-read) one sample per strobe.
- Sits between the audio sample source and the FIFO; muxes FIFO output, bypass or mute onto the downstream stream.

---
 rtl/delay_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_delay_seq_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/delay_seq_ctrl.sv
// rtl/delay_seq_ctrl.sv - sequencer turning an external sample FIFO into a programmable delay line
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   sample_valid, din   input sample strobe and data
//   delay_num           requested delay in samples, sampled with each strobe
//   flush               synchronous restart of the delay line
//   fifo_data/_wr_en    FIFO write side (fifo_data mirrors din)
//   fifo_rd_en, fifo_q  FIFO read side, data valid one cycle after the read
//   fifo_clr            one-cycle FIFO clear pulse
//   dout, out_valid     delayed (or bypassed / muted) output sample and strobe
//   state_busy          line is filling, growing or shrinking
//   err                 sticky internal count error
module delay_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] din,
  input  logic [CNT_W-1:0]  delay_num,
  input  logic              flush,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_wr_en,
  output logic              fifo_rd_en,
  output logic              fifo_clr,
  input  logic [DATA_W-1:0] fifo_q,
  output logic [DATA_W-1:0] dout,
  output logic              out_valid,
  output logic              state_busy,
  output logic              err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_GROW, S_SHRINK} state_t;
  typedef enum logic [1:0] {SEL_MUTE, SEL_BYP, SEL_FIFO} sel_t;

  state_t            state_q, state_d;
  sel_t              sel_q, sel_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]  tgt_in;
  logic [DATA_W-1:0] byp_q, byp_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              clr_q, clr_d;
  logic              xrd_q, xrd_d;
  logic              pend_q, pend_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              range_bad;
  logic              wr_en, rd_en;

  always_comb begin
    tgt_in    = (delay_num > MAX_CNT) ? MAX_CNT : delay_num;
    // In RUN the occupancy must equal the last latched target; anything else
    // means the count has drifted from what the FIFO really holds.
    range_bad = (count_q > MAX_CNT) || ((state_q == S_RUN) && (count_q != target_q));

    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    sel_d    = sel_q;
    byp_d    = byp_q;
    clr_d    = 1'b0;
    xrd_d    = 1'b0;
    pend_d   = 1'b0;
    err_d    = err_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;

    if (flush) begin
      // A coincident sample is dropped but still produces a muted output slot.
      count_d = '0;
      state_d = S_FILL;
      clr_d   = 1'b1;
      if (sample_valid) begin
        target_d = tgt_in;
        pend_d   = 1'b1;
        sel_d    = SEL_MUTE;
      end
    end else if (sample_valid) begin
      target_d = tgt_in;
      pend_d   = 1'b1;
      sel_d    = SEL_MUTE;
      byp_d    = din;
      if (range_bad) begin
        err_d = 1'b1;
      end else if (tgt_in == '0) begin
        // Bypass: stale FIFO contents are discarded so a later refill starts clean.
        sel_d   = SEL_BYP;
        clr_d   = (count_q != '0);
        count_d = '0;
        state_d = S_RUN;
      end else if (count_q < tgt_in) begin
        wr_en   = 1'b1;
        count_d = count_q + 1'b1;
        if (count_d == tgt_in)    state_d = S_RUN;
        else if (state_q == S_FILL) state_d = S_FILL;
        else                      state_d = S_GROW;
      end else begin
        wr_en = 1'b1;
        rd_en = 1'b1;
        sel_d = SEL_FIFO;
        if (count_q > tgt_in) begin
          // Second read in the following cycle drops one sample from the line.
          xrd_d   = 1'b1;
          count_d = count_q - 1'b1;
        end
        state_d = (count_d == tgt_in) ? S_RUN : S_SHRINK;
      end
    end

    // Output stage: fifo_q is valid in the cycle after the strobe.
    valid_d = pend_q;
    dout_d  = dout_q;
    if (pend_q) begin
      case (sel_q)
        SEL_BYP:  dout_d = byp_q;
        SEL_FIFO: dout_d = fifo_q;
        default:  dout_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FILL;
      sel_q    <= SEL_MUTE;
      count_q  <= '0;
      target_q <= '0;
      byp_q    <= '0;
      dout_q   <= '0;
      clr_q    <= 1'b0;
      xrd_q    <= 1'b0;
      pend_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      count_q  <= count_d;
      target_q <= target_d;
      byp_q    <= byp_d;
      dout_q   <= dout_d;
      clr_q    <= clr_d;
      xrd_q    <= xrd_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign fifo_data  = din;
  assign fifo_wr_en = wr_en;
  assign fifo_rd_en = rd_en | xrd_q;
  assign fifo_clr   = clr_q;
  assign dout       = dout_q;
  assign out_valid  = valid_q;
  assign state_busy = (state_q != S_RUN);
  assign err        = err_q;

endmodule

// File: tb/tb_delay_seq_ctrl.sv
// tb/tb_delay_seq_ctrl.sv - self-checking bench for delay_seq_ctrl
module tb_delay_seq_ctrl;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;
  localparam int CNT_W  = 13;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              sample_valid;
  logic [DATA_W-1:0] din;
  logic [CNT_W-1:0]  delay_num;
  logic              flush;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_wr_en;
  logic              fifo_rd_en;
  logic              fifo_clr;
  logic [DATA_W-1:0] fifo_q;
  logic [DATA_W-1:0] dout;
  logic              out_valid;
  logic              state_busy;
  logic              err;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] fq[$];     // external FIFO contents
  logic [DATA_W-1:0] line[$];   // reference: logical delay-line contents
  logic [DATA_W-1:0] exp_q[$];  // reference: expected outputs in order
  bit                busy_exp;
  logic [DATA_W-1:0] ramp;

  always #5 clk = ~clk;

  delay_seq_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .din(din),
    .delay_num(delay_num), .flush(flush), .fifo_data(fifo_data),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_clr(fifo_clr),
    .fifo_q(fifo_q), .dout(dout), .out_valid(out_valid),
    .state_busy(state_busy), .err(err)
  );

  // Single-clock FIFO: registered read data, synchronous clear.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fq.delete();
      fifo_q <= '0;
    end else if (fifo_clr) begin
      fq.delete();
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_q <= fq.pop_front();
      if (fifo_wr_en) fq.push_back(fifo_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) chk("out_valid_unexpected", 32'(out_valid), 32'd0);
      else                   chk("dout", 32'(dout), 32'(exp_q.pop_front()));
    end
  end

  // One strobe: drive, predict from the line model, check enables and pulses.
  task automatic strobe(input logic [DATA_W-1:0] x, input int dn, input bit f, input int gap);
    int t;
    bit e_wr, e_rd, e_xrd, e_clr;
    logic [DATA_W-1:0] e;
    t = (dn > DEPTH-1) ? DEPTH-1 : dn;
    @(negedge clk);
    chk("busy", 32'(state_busy), 32'(busy_exp));
    sample_valid = 1'b1; din = x; delay_num = CNT_W'(dn); flush = f;
    e_wr = 0; e_rd = 0; e_xrd = 0; e_clr = 0; e = '0;
    if (f) begin
      e_clr = 1; line.delete(); busy_exp = 1;
    end else if (t == 0) begin
      e = x; e_clr = (line.size() != 0); line.delete(); busy_exp = 0;
    end else begin
      e_wr = 1;
      e_rd = (line.size() >= t);
      e_xrd = (line.size() > t);
      line.push_back(x);
      if (e_rd) e = line.pop_front();
      if (e_xrd) void'(line.pop_front());
      busy_exp = (line.size() != t);
    end
    exp_q.push_back(e);
    #1;
    chk("wr_en", 32'(fifo_wr_en), 32'(e_wr));
    chk("rd_en", 32'(fifo_rd_en), 32'(e_rd));
    @(negedge clk);
    sample_valid = 1'b0; flush = 1'b0;
    #1;
    chk("rd_en_extra", 32'(fifo_rd_en), 32'(e_xrd));
    chk("fifo_clr", 32'(fifo_clr), 32'(e_clr));
    chk("wr_en_idle", 32'(fifo_wr_en), 32'd0);
    chk("err", 32'(err), 32'd0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic ramp_run(input int dn, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      strobe(ramp, dn, 1'b0, 1);
      ramp++;
    end
  endtask

  task automatic reset_checks();
    chk("rst_wr", 32'(fifo_wr_en), 32'd0);
    chk("rst_rd", 32'(fifo_rd_en), 32'd0);
    chk("rst_clr", 32'(fifo_clr), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(state_busy), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; sample_valid = 1'b0; din = '0; delay_num = '0; flush = 1'b0;
    busy_exp = 1; ramp = 16'd1;
    repeat (3) @(negedge clk);
    reset_checks();
    reset_n = 1'b1;

    ramp_run(4, 8);      // fill then run at delay 4
    ramp_run(6, 6);      // grow to 6
    ramp_run(3, 6);      // shrink to 3
    ramp_run(4, 2);      // back to 4
    ramp_run(0, 3);      // bypass, clears the line
    ramp_run(5, 7);      // refill
    strobe(ramp, 5, 1'b1, 1); ramp++;   // flush coincident with a strobe
    ramp_run(5, 8);

    for (int i = 0; i < 80; i++)
      strobe(16'($urandom), int'($urandom_range(0, 10)), ($urandom_range(0, 19) == 0),
             int'($urandom_range(0, 2)));

    ramp_run(8191, DEPTH - 1 + 6);  // clamps to 4095
    chk("err_after_max", 32'(err), 32'd0);

    strobe(ramp, 4000, 1'b0, 0); ramp++;  // enter SHRINK, extra read pending
    reset_n = 1'b0;
    #1;
    reset_checks();
    exp_q.delete(); line.delete(); busy_exp = 1;
    @(negedge clk);
    reset_n = 1'b1;

    ramp_run(2, 6);
    repeat (4) @(negedge clk);
    chk("outputs_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
